// File: rtl/id_stage.sv
// Instruction decode stage: field split, 15-entry register file, control decode, condition check, hazard detection.
// Latency: fully combinational decode; register-file writes commit on the rising clk edge.
// Backpressure: raises Hazard in the same cycle to stall IF and PC; stalled decodes have their side-effecting controls zeroed.
//
// Ports:
//   clk, rst                     clock; asynchronous active-high reset (R[i] = i)
//   Instruction, PC_in, Status   IF/ID register contents and current NZCV flags
//   WB_WB_EN, WB_Dest, WB_Value  write-back port into the register file
//   EXE_*, MEM_*, Forward_EN     hazard sources from later stages
//   MEM_R_EN .. Status_out       decoded fields and operands for the ID/EX register
//   Hazard                       stall request
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instruction,
    input  logic [31:0] PC_in,
    input  logic [3:0]  Status,
    input  logic        WB_WB_EN,
    input  logic [3:0]  WB_Dest,
    input  logic [31:0] WB_Value,
    input  logic        EXE_WB_EN,
    input  logic [3:0]  EXE_Dest,
    input  logic        EXE_MEM_R_EN,
    input  logic        MEM_WB_EN,
    input  logic [3:0]  MEM_Dest,
    input  logic        Forward_EN,
    output logic        MEM_R_EN,
    output logic        MEM_W_EN,
    output logic        WB_EN,
    output logic        Imm,
    output logic        B,
    output logic        S,
    output logic [3:0]  EX_CMD,
    output logic [3:0]  Dest,
    output logic [3:0]  src1,
    output logic [3:0]  src2,
    output logic [11:0] shifter_operand,
    output logic [23:0] signed_immediate,
    output logic [31:0] PC_out,
    output logic [31:0] Val_Rn,
    output logic [31:0] Val_Rm,
    output logic [3:0]  Status_out,
    output logic        Hazard
);

    // Instruction fields
    logic [3:0] cond;
    logic [1:0] mode;
    logic       i_bit;
    logic [3:0] opcode;
    logic       s_l;
    logic [3:0] rn;
    logic [3:0] rd;
    logic [3:0] rm;

    assign cond   = Instruction[31:28];
    assign mode   = Instruction[27:26];
    assign i_bit  = Instruction[25];
    assign opcode = Instruction[24:21];
    assign s_l    = Instruction[20];
    assign rn     = Instruction[19:16];
    assign rd     = Instruction[15:12];
    assign rm     = Instruction[3:0];

    logic is_str;
    assign is_str = (mode == 2'b01) && !s_l;

    assign src1 = rn;
    assign src2 = is_str ? rd : rm;

    // Register file: R0..R14; address 15 is the PC and is never stored.
    logic [31:0] regs [0:14];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                regs[i] <= 32'(i);
            end
        end else if (WB_WB_EN && (WB_Dest != 4'd15)) begin
            regs[WB_Dest] <= WB_Value;
        end
    end

    // Write-through bypass is suppressed during reset so reads show the reset contents.
    logic wb_bypass;
    assign wb_bypass = WB_WB_EN && !rst && (WB_Dest != 4'd15);

    always_comb begin
        if (src1 == 4'd15) begin
            Val_Rn = PC_in;
        end else if (wb_bypass && (WB_Dest == src1)) begin
            Val_Rn = WB_Value;
        end else begin
            Val_Rn = regs[src1];
        end
    end

    always_comb begin
        if (src2 == 4'd15) begin
            Val_Rm = PC_in;
        end else if (wb_bypass && (WB_Dest == src2)) begin
            Val_Rm = WB_Value;
        end else begin
            Val_Rm = regs[src2];
        end
    end

    // Control decode before condition/hazard squashing
    logic dec_mem_r, dec_mem_w, dec_wb, dec_b, dec_s;

    always_comb begin
        EX_CMD    = 4'b0000;
        dec_mem_r = 1'b0;
        dec_mem_w = 1'b0;
        dec_wb    = 1'b0;
        dec_b     = 1'b0;
        dec_s     = 1'b0;
        case (mode)
            2'b00: begin
                dec_wb = 1'b1;
                dec_s  = s_l;
                case (opcode)
                    4'b1101: EX_CMD = 4'b0001;                  // MOV
                    4'b1111: EX_CMD = 4'b1001;                  // MVN
                    4'b0100: EX_CMD = 4'b0010;                  // ADD
                    4'b0101: EX_CMD = 4'b0011;                  // ADC
                    4'b0010: EX_CMD = 4'b0100;                  // SUB
                    4'b0110: EX_CMD = 4'b0101;                  // SBC
                    4'b0000: EX_CMD = 4'b0110;                  // AND
                    4'b1100: EX_CMD = 4'b0111;                  // ORR
                    4'b0001: EX_CMD = 4'b1000;                  // EOR
                    4'b1010: begin EX_CMD = 4'b0100; dec_wb = 1'b0; end  // CMP
                    4'b1000: begin EX_CMD = 4'b0110; dec_wb = 1'b0; end  // TST
                    default: begin dec_wb = 1'b0; dec_s = 1'b0; end
                endcase
            end
            2'b01: begin
                EX_CMD    = 4'b0010;
                dec_mem_r = s_l;
                dec_wb    = s_l;
                dec_mem_w = !s_l;
            end
            2'b10: dec_b = 1'b1;
            default: ;
        endcase
    end

    // Condition evaluation, Status = {N, Z, C, V}
    logic flag_n, flag_z, flag_c, flag_v, cond_ok;
    assign {flag_n, flag_z, flag_c, flag_v} = Status;

    always_comb begin
        case (cond)
            4'h0: cond_ok = flag_z;
            4'h1: cond_ok = !flag_z;
            4'h2: cond_ok = flag_c;
            4'h3: cond_ok = !flag_c;
            4'h4: cond_ok = flag_n;
            4'h5: cond_ok = !flag_n;
            4'h6: cond_ok = flag_v;
            4'h7: cond_ok = !flag_v;
            4'h8: cond_ok = flag_c && !flag_z;
            4'h9: cond_ok = !flag_c || flag_z;
            4'hA: cond_ok = (flag_n == flag_v);
            4'hB: cond_ok = (flag_n != flag_v);
            4'hC: cond_ok = !flag_z && (flag_n == flag_v);
            4'hD: cond_ok = flag_z || (flag_n != flag_v);
            4'hE: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // Hazard detection: which sources are actually read by this instruction
    logic uses_rn, two_src;
    assign uses_rn = !((mode == 2'b00) && ((opcode == 4'b1101) || (opcode == 4'b1111)))
                     && (mode != 2'b10);
    assign two_src = ((mode == 2'b00) && !i_bit) || is_str;

    logic exe_hit, mem_hit, hz_nofwd, hz_fwd;
    assign exe_hit = (uses_rn && (src1 == EXE_Dest)) || (two_src && (src2 == EXE_Dest));
    assign mem_hit = (uses_rn && (src1 == MEM_Dest)) || (two_src && (src2 == MEM_Dest));
    assign hz_nofwd = (EXE_WB_EN && exe_hit) || (MEM_WB_EN && mem_hit);
    // With forwarding only a load in EXE cannot be forwarded in time.
    assign hz_fwd   = EXE_MEM_R_EN && exe_hit;
    assign Hazard   = Forward_EN ? hz_fwd : hz_nofwd;

    logic squash;
    assign squash = !cond_ok || Hazard;

    assign MEM_R_EN = dec_mem_r && !squash;
    assign MEM_W_EN = dec_mem_w && !squash;
    assign WB_EN    = dec_wb    && !squash;
    assign B        = dec_b     && !squash;
    assign S        = dec_s     && !squash;

    assign Imm              = i_bit;
    assign Dest             = rd;
    assign shifter_operand  = Instruction[11:0];
    assign signed_immediate = Instruction[23:0];
    assign PC_out           = PC_in;
    assign Status_out       = Status;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage with a tag/value scoreboard drained after each step.
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic [31:0] Instruction, PC_in, WB_Value;
    logic [3:0]  Status, WB_Dest, EXE_Dest, MEM_Dest;
    logic        WB_WB_EN, EXE_WB_EN, EXE_MEM_R_EN, MEM_WB_EN, Forward_EN;
    logic        MEM_R_EN, MEM_W_EN, WB_EN, Imm, B, S, Hazard;
    logic [3:0]  EX_CMD, Dest, src1, src2, Status_out;
    logic [11:0] shifter_operand;
    logic [23:0] signed_immediate;
    logic [31:0] PC_out, Val_Rn, Val_Rm;

    id_stage dut (
        .clk(clk), .rst(rst), .Instruction(Instruction), .PC_in(PC_in), .Status(Status),
        .WB_WB_EN(WB_WB_EN), .WB_Dest(WB_Dest), .WB_Value(WB_Value),
        .EXE_WB_EN(EXE_WB_EN), .EXE_Dest(EXE_Dest), .EXE_MEM_R_EN(EXE_MEM_R_EN),
        .MEM_WB_EN(MEM_WB_EN), .MEM_Dest(MEM_Dest), .Forward_EN(Forward_EN),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN), .Imm(Imm), .B(B), .S(S),
        .EX_CMD(EX_CMD), .Dest(Dest), .src1(src1), .src2(src2),
        .shifter_operand(shifter_operand), .signed_immediate(signed_immediate),
        .PC_out(PC_out), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .Status_out(Status_out),
        .Hazard(Hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic expect_out(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] observe(input string tag);
        case (tag)
            "MEM_R_EN":   return 32'(MEM_R_EN);
            "MEM_W_EN":   return 32'(MEM_W_EN);
            "WB_EN":      return 32'(WB_EN);
            "Imm":        return 32'(Imm);
            "B":          return 32'(B);
            "S":          return 32'(S);
            "EX_CMD":     return 32'(EX_CMD);
            "Dest":       return 32'(Dest);
            "src1":       return 32'(src1);
            "src2":       return 32'(src2);
            "shifter":    return 32'(shifter_operand);
            "simm":       return 32'(signed_immediate);
            "PC_out":     return PC_out;
            "Val_Rn":     return Val_Rn;
            "Val_Rm":     return Val_Rm;
            "Status_out": return 32'(Status_out);
            "Hazard":     return 32'(Hazard);
            default:      return 32'hxxxxxxxx;
        endcase
    endfunction

    // Let combinational outputs settle (well before the next rising edge), then compare.
    task automatic check_all();
        exp_t        e;
        logic [31:0] o;
        #2;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.tag);
            tests++;
            assert (o === e.val) else begin
                fails++;
                $error("FAIL %s: observed %h expected %h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic clear_hazard_srcs();
        EXE_WB_EN = 0; EXE_Dest = 0; EXE_MEM_R_EN = 0;
        MEM_WB_EN = 0; MEM_Dest = 0; Forward_EN = 0;
    endtask

    // Reference condition: even codes are the base test, odd codes its inverse.
    function automatic logic cond_ref(input logic [3:0] cc, input logic [3:0] st);
        logic n, z, c, v, base;
        {n, z, c, v} = st;
        case (cc[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (cc == 4'hF) return 1'b0;
        return cc[0] ? ~base : base;
    endfunction

    logic [3:0] st_tab  [8]  = '{4'b0000, 4'b0100, 4'b0010, 4'b1000, 4'b0001, 4'b1001, 4'b0110, 4'b1010};
    logic [3:0] op_tab  [16] = '{4'b1101, 4'b1111, 4'b0100, 4'b0101, 4'b0010, 4'b0110, 4'b0000, 4'b1100,
                                 4'b0001, 4'b1010, 4'b1000, 4'b0011, 4'b0111, 4'b1011, 4'b1001, 4'b1110};
    logic [3:0] cmd_tab [16] = '{4'b0001, 4'b1001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
                                 4'b1000, 4'b0100, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic       wb_tab  [16] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    logic       ok_tab  [16] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0;
        Instruction = 32'hE083000E;   // ADD R0, R3, R14
        PC_in = 32'h0000_0100; Status = 4'b0000;
        WB_WB_EN = 0; WB_Dest = 0; WB_Value = 0;
        clear_hazard_srcs();
        #1 rst = 1;

        // Reset contents visible through both read ports
        expect_out("Val_Rn", 32'd3);
        expect_out("Val_Rm", 32'd14);
        expect_out("PC_out", 32'h0000_0100);
        expect_out("Hazard", 0);
        check_all();

        // Writes are blocked while reset is held, including the edge where reset is sampled high
        WB_WB_EN = 1; WB_Dest = 4'd3; WB_Value = 32'h0000_0055;
        expect_out("Val_Rn", 32'd3);
        check_all();
        @(posedge clk);
        #1 rst = 0; WB_WB_EN = 0;
        expect_out("Val_Rn", 32'd3);
        check_all();

        // Write-through bypass on the same cycle as the write
        @(negedge clk);
        WB_WB_EN = 1; WB_Dest = 4'd5; WB_Value = 32'hDEADBEEF;
        Instruction = 32'hE0812005;   // ADD R2, R1, R5
        expect_out("Val_Rm", 32'hDEADBEEF);
        expect_out("Val_Rn", 32'd1);
        expect_out("EX_CMD", 4'b0010);
        expect_out("WB_EN", 1);
        expect_out("Dest", 4'd2);
        expect_out("src1", 4'd1);
        expect_out("src2", 4'd5);
        expect_out("shifter", 12'h005);
        expect_out("Hazard", 0);
        check_all();

        // Value committed by the edge
        @(negedge clk);
        WB_WB_EN = 0;
        expect_out("Val_Rm", 32'hDEADBEEF);
        check_all();

        // Asynchronous reset mid-run restores R5 immediately
        @(negedge clk);
        rst = 1;
        expect_out("Val_Rm", 32'd5);
        check_all();
        @(negedge clk);
        rst = 0;

        // Conditional execution
        Instruction = 32'h00812005; Status = 4'b0000;
        expect_out("WB_EN", 0);
        expect_out("EX_CMD", 4'b0010);
        check_all();
        Status = 4'b0100;
        expect_out("WB_EN", 1);
        expect_out("Status_out", 4'b0100);
        check_all();

        for (int c = 0; c < 16; c++) begin
            for (int k = 0; k < 8; k++) begin
                Instruction = {c[3:0], 28'h0812005};
                Status = st_tab[k];
                expect_out("WB_EN", 32'(cond_ref(c[3:0], st_tab[k])));
                check_all();
            end
        end

        // Data-processing opcode table with S set
        Status = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            Instruction = {4'hE, 2'b00, 1'b0, op_tab[k], 1'b1, 4'h1, 4'h2, 8'h00, 4'h5};
            expect_out("EX_CMD", 32'(cmd_tab[k]));
            expect_out("WB_EN", 32'(wb_tab[k]));
            expect_out("S", 32'(ok_tab[k]));
            expect_out("B", 0);
            check_all();
        end

        // Hazards without forwarding
        Forward_EN = 0; EXE_WB_EN = 1; EXE_Dest = 4'd1;
        Instruction = 32'hE0812005;
        expect_out("Hazard", 1);
        expect_out("WB_EN", 0);
        expect_out("EX_CMD", 4'b0010);
        check_all();
        Instruction = 32'hE1A02001;   // MOV R2, R1
        expect_out("Hazard", 1);
        check_all();
        Instruction = 32'hE3A02001;   // MOV R2, #1
        expect_out("Hazard", 0);
        expect_out("WB_EN", 1);
        expect_out("Imm", 1);
        check_all();
        EXE_WB_EN = 0; MEM_WB_EN = 1; MEM_Dest = 4'd5;
        Instruction = 32'hE0812005;
        expect_out("Hazard", 1);
        check_all();

        // Forwarding: only a load in EXE stalls
        Forward_EN = 1;
        expect_out("Hazard", 0);
        check_all();
        MEM_WB_EN = 0; EXE_WB_EN = 1; EXE_Dest = 4'd1; EXE_MEM_R_EN = 0;
        expect_out("Hazard", 0);
        expect_out("WB_EN", 1);
        check_all();
        EXE_MEM_R_EN = 1;
        expect_out("Hazard", 1);
        expect_out("WB_EN", 0);
        check_all();

        // Store / load
        clear_hazard_srcs();
        Instruction = 32'hE5812000;   // STR R2, [R1]
        expect_out("MEM_W_EN", 1);
        expect_out("MEM_R_EN", 0);
        expect_out("WB_EN", 0);
        expect_out("src2", 4'd2);
        expect_out("Val_Rm", 32'd2);
        expect_out("EX_CMD", 4'b0010);
        expect_out("S", 0);
        check_all();
        EXE_WB_EN = 1; EXE_Dest = 4'd2;
        expect_out("Hazard", 1);
        expect_out("MEM_W_EN", 0);
        check_all();
        clear_hazard_srcs();
        Instruction = 32'hE5912000;   // LDR R2, [R1]
        expect_out("MEM_R_EN", 1);
        expect_out("WB_EN", 1);
        expect_out("MEM_W_EN", 0);
        expect_out("src2", 4'd0);
        check_all();

        // Branch: Rn unused, no hazard on R0
        Instruction = 32'hEA000010;
        EXE_WB_EN = 1; EXE_Dest = 4'd0;
        expect_out("B", 1);
        expect_out("WB_EN", 0);
        expect_out("EX_CMD", 0);
        expect_out("simm", 24'h000010);
        expect_out("Hazard", 0);
        check_all();
        clear_hazard_srcs();

        // Writes to R15 dropped; reads of 15 return PC_in
        @(negedge clk);
        PC_in = 32'hCAFE0000;
        WB_WB_EN = 1; WB_Dest = 4'd15; WB_Value = 32'h12345678;
        Instruction = 32'hE08F000E;   // ADD R0, R15, R14
        expect_out("Val_Rn", 32'hCAFE0000);
        expect_out("Val_Rm", 32'd14);
        check_all();
        @(negedge clk);
        WB_WB_EN = 0;
        expect_out("Val_Rn", 32'hCAFE0000);
        expect_out("Val_Rm", 32'd14);
        check_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
